seq_monitor: RTL

Downstream checker for the 3-bit mod-5 sequence counter. It consumes the counter's Q bus, which follows the 0→1→3→7→2→0 sequence.
- Acquires lock on the legal sequence, then flywheels through single glitches.
- Flags illegal codes (4, 5, 6) and out-of-order transitions.
- Keeps a saturating error count and emits a once-per-period marker.
- Sits between the counter and any status/control logic that relies on counter integrity.

---
 rtl/seq_mon_pkg.sv | 34 +++
 rtl/seq_decode.sv | 18 +
 rtl/seq_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/seq_mon_pkg.sv
// Shared constants, state encoding and code lookups for the mod-5 sequence monitor.
package seq_mon_pkg;

  localparam int SEQ_LEN = 5;
  localparam logic [2:0] SEQ [SEQ_LEN] = '{3'd0, 3'd1, 3'd3, 3'd7, 3'd2};

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] idx;
  } code_info_t;

  function automatic code_info_t idx_of(input logic [2:0] code);
    code_info_t r;
    r = '{legal: 1'b0, idx: 3'd0};
    for (int i = 0; i < SEQ_LEN; i++)
      if (code == SEQ[i]) begin
        r.legal = 1'b1;
        r.idx   = 3'(i);
      end
    return r;
  endfunction

  // Illegal codes have no successor; 0 is returned so callers see a defined value.
  function automatic logic [2:0] next_code(input logic [2:0] code);
    code_info_t info;
    int         n;
    info = idx_of(code);
    n    = (info.idx == 3'd4) ? 0 : int'(info.idx) + 1;
    return info.legal ? SEQ[n] : 3'd0;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational code decoder: legality, sequence index and successor code.
module seq_decode
  import seq_mon_pkg::*;
(
  input  logic [2:0] code,
  output logic       legal,
  output logic [2:0] idx,
  output logic [2:0] nxt
);

  code_info_t info;

  assign info  = idx_of(code);
  assign legal = info.legal;
  assign idx   = info.idx;
  assign nxt   = next_code(code);

endmodule

// File: rtl/seq_monitor.sv
// Lock/flywheel checker for the 0-1-3-7-2 counter sequence with error accounting.
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int LOCK_CNT = 5,
  parameter int LOSS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       q_in,
  input  logic             q_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             illegal_pulse,
  output logic             wrap_pulse,
  output logic [2:0]       pos,
  output logic [CNT_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  state_t            state, state_nx;
  logic [2:0]        prev, prev_nx, pos_nx;
  logic [GW-1:0]     good_run, good_nx;
  logic [BW-1:0]     bad_run, bad_nx;
  logic [CNT_W-1:0]  cnt_nx;
  logic              err_nx, ill_nx, wrap_nx, inc;

  logic       q_legal, p_legal;
  logic [2:0] q_idx, p_idx, q_nxt_unused, expected, exp_idx;
  logic       match;

  seq_decode u_dec_q (.code(q_in), .legal(q_legal), .idx(q_idx), .nxt(q_nxt_unused));
  seq_decode u_dec_p (.code(prev), .legal(p_legal), .idx(p_idx), .nxt(expected));

  assign match   = p_legal && (q_in == expected);
  assign exp_idx = (p_idx == 3'd4) ? 3'd0 : p_idx + 3'd1;

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    pos_nx   = pos;
    good_nx  = good_run;
    bad_nx   = bad_run;
    err_nx   = 1'b0;
    ill_nx   = 1'b0;
    wrap_nx  = 1'b0;
    inc      = 1'b0;
    if (q_valid) begin
      ill_nx = !q_legal;
      case (state)
        HUNT: if (q_legal) begin
          prev_nx  = q_in;
          pos_nx   = q_idx;
          good_nx  = '0;
          state_nx = ACQUIRE;
        end
        ACQUIRE: begin
          if (!q_legal) state_nx = HUNT;
          else begin
            prev_nx = q_in;
            pos_nx  = q_idx;
            if (!match) good_nx = '0;
            else begin
              good_nx = good_run + GW'(1);
              if (good_run == GW'(LOCK_CNT - 1)) begin
                state_nx = LOCKED;
                bad_nx   = '0;
              end
            end
          end
        end
        LOCKED: begin
          if (match) begin
            prev_nx = q_in;
            pos_nx  = q_idx;
            bad_nx  = '0;
            wrap_nx = (q_in == 3'd0);
          end else begin
            // Flywheel: assume the counter advanced and only this sample glitched.
            err_nx  = 1'b1;
            inc     = 1'b1;
            prev_nx = expected;
            pos_nx  = exp_idx;
            bad_nx  = bad_run + BW'(1);
            if (bad_run == BW'(LOSS_CNT - 1)) state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
    cnt_nx = err_count;
    if (clr_cnt)                     cnt_nx = inc ? CNT_W'(1) : '0;
    else if (inc && err_count != '1) cnt_nx = err_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= HUNT;
      prev          <= '0;
      pos           <= '0;
      good_run      <= '0;
      bad_run       <= '0;
      err_count     <= '0;
      err_pulse     <= 1'b0;
      illegal_pulse <= 1'b0;
      wrap_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      prev          <= prev_nx;
      pos           <= pos_nx;
      good_run      <= good_nx;
      bad_run       <= bad_nx;
      err_count     <= cnt_nx;
      err_pulse     <= err_nx;
      illegal_pulse <= ill_nx;
      wrap_pulse    <= wrap_nx;
    end
  end

  assign locked = (state == LOCKED);

endmodule
